dma_write: RTL and testbench
============================

DMA_WRITE -- requirements
Module: dma_write

Interface
REQ-001 SHALL have parameter C_M_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 128, data width; BEAT_BYTES = width/8, power of two.
REQ-004 SHALL have parameters C_M_AXI_AWUSER_WIDTH, C_M_AXI_WUSER_WIDTH and C_M_AXI_BUSER_WIDTH, each default 0, user-signal widths.
REQ-005 ACLK  in  1  single clock, all logic on rising edge.
REQ-006 ARESETN  in  1  reset, synchronous, active-low.
REQ-007 i_start  in  1  rising edge starts a transfer, honoured only in S_IDLE.
REQ-008 i_base_addr  in  32  destination byte address; low log2(BEAT_BYTES) bits are forced to zero.
REQ-009 i_byte_len  in  32  byte count; 0 means no transfer.
REQ-010 o_busy / o_done / o_error  out  1 each  busy level / 1-cycle finish pulse / BRESP error latched until next start.
REQ-011 i_data  in  DATA_WIDTH  stream payload; i_valid in 1; o_ready out 1 (valid/ready handshake).
REQ-012 M_AXI_AWADDR out ADDR_WIDTH, M_AXI_AWLEN out 8, M_AXI_AWSIZE out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-013 M_AXI_WDATA out DATA_WIDTH, M_AXI_WSTRB out DATA_WIDTH/8, M_AXI_WLAST out 1, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-014 M_AXI_BID in ID_WIDTH, M_AXI_BRESP in 2, M_AXI_BUSER in BUSER_WIDTH, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-015 Constant tie-offs SHALL be: AWID=0, AWBURST=INCR (01), AWLOCK=0, AWCACHE=0011, AWPROT=000, AWQOS=0000, AWUSER=0, WUSER=0.

Function
REQ-016 AWSIZE SHALL equal log2(BEAT_BYTES).
REQ-017 FSM SHALL have states S_IDLE, S_AW, S_W and S_B, with one burst outstanding at a time.
REQ-018 In S_IDLE, a start edge with len≠0 SHALL latch the address and length, set busy, clear error, and go to S_AW.
REQ-019 In S_IDLE, a start edge with len=0 SHALL pulse o_done the next cycle and leave busy at 0.
REQ-020 Burst beats SHALL be min(ceil(bytes_rem/BEAT_BYTES), (4096 - addr[11:0])/BEAT_BYTES, 256), computed combinationally.
REQ-021 In S_AW, AWVALID=1 and AWLEN=beats-1 SHALL be held stable until AWREADY.
REQ-022 On the AW handshake, the FSM SHALL load the beat counter, advance cur_addr by beats*BEAT_BYTES, and go to S_W.
REQ-023 In S_W, the stream SHALL pass through: WDATA=i_data, WVALID=i_valid, o_ready=WREADY, with no added latency.
REQ-024 Outside S_W, o_ready and WVALID SHALL be 0.
REQ-025 Each W handshake SHALL decrement the beat counter and subtract min(BEAT_BYTES, bytes_rem) from bytes_rem.
REQ-026 WLAST SHALL be asserted on the beat where the counter equals 1; after that handshake the FSM goes to S_B.
REQ-027 WSTRB SHALL be all ones, except on the final beat of the transfer, where only the low (bytes_rem mod BEAT_BYTES) lanes are set when that remainder is non-zero.
REQ-028 In S_B, BREADY SHALL be 1; any BRESP≠00 SHALL set o_error.
REQ-029 On the B handshake, the FSM SHALL go to S_AW if bytes_rem≠0.
REQ-030 On the B handshake with bytes_rem=0, the FSM SHALL go to S_IDLE, clear o_busy, and pulse o_done for one cycle.
REQ-031 An error SHALL NOT abort the transfer; all remaining bursts SHALL be issued.
REQ-032 Start edges while busy SHALL be ignored.

Reset
REQ-033 While ARESETN=0 at a clock edge, the block SHALL enter S_IDLE.
REQ-034 While ARESETN=0 at a clock edge, all counters SHALL be zeroed.
REQ-035 While ARESETN=0 at a clock edge, o_busy, o_done, o_error, AWVALID, WVALID, BREADY and o_ready SHALL be 0.
REQ-036 While ARESETN=0 at a clock edge, the start-edge register SHALL be 0.
REQ-037 A reset asserted mid-transfer SHALL abandon it without completing the AXI handshakes.

Configuration
REQ-038 With macro DMA_WRITE_PARTIAL_STRB_EN defined, WSTRB on the final beat SHALL follow REQ-027.
REQ-039 Without DMA_WRITE_PARTIAL_STRB_EN, WSTRB SHALL be all ones on every beat, and the length is effectively rounded up to whole beats.

Verification (DATA_WIDTH=128)
REQ-040 base=0x1000, len=64, AWREADY/WREADY/BVALID fixed at 1 -> one AW with AWLEN=3, 4 beats, WLAST on beat 4, o_done 1 cycle after B.
REQ-041 base=0x1FC0, len=128 -> AW 0x1FC0 with AWLEN=3, then AW 0x2000 with AWLEN=3 (4 KB split).
REQ-042 base=0x0, len=4128 -> bursts of 256 beats then 2 beats; 258 W beats total.
REQ-043 len=20 with the macro defined -> 2 beats; beat-2 WSTRB=0x000F; without the macro, WSTRB=0xFFFF.
REQ-044 Second burst returns BRESP=10 -> o_error=1, transfer still completes, o_done pulses; the next start clears o_error.
REQ-045 Random WREADY/i_valid stalls with a reset pulse mid-burst -> all outputs 0 next cycle; a new start then completes correctly.

Source files
------------

// File: rtl/dma_write_if.sv
// AXI4 write-channel bundle (AW, W, B) for dma_write.
//   master modport : seen by the DMA engine (drives AW/W, BREADY)
//   slave  modport : seen by the memory/interconnect side
// User-signal widths of 0 are carried as 1-bit placeholders.
interface dma_write_if #(
   parameter int C_M_AXI_ID_WIDTH     = 1,
   parameter int C_M_AXI_ADDR_WIDTH   = 32,
   parameter int C_M_AXI_DATA_WIDTH   = 128,
   parameter int C_M_AXI_AWUSER_WIDTH = 0,
   parameter int C_M_AXI_WUSER_WIDTH  = 0,
   parameter int C_M_AXI_BUSER_WIDTH  = 0
) ();
   localparam int AWU_W = (C_M_AXI_AWUSER_WIDTH > 0) ? C_M_AXI_AWUSER_WIDTH : 1;
   localparam int WU_W  = (C_M_AXI_WUSER_WIDTH  > 0) ? C_M_AXI_WUSER_WIDTH  : 1;
   localparam int BU_W  = (C_M_AXI_BUSER_WIDTH  > 0) ? C_M_AXI_BUSER_WIDTH  : 1;

   logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
   logic [7:0]                      M_AXI_AWLEN;
   logic [2:0]                      M_AXI_AWSIZE;
   logic [1:0]                      M_AXI_AWBURST;
   logic                            M_AXI_AWLOCK;
   logic [3:0]                      M_AXI_AWCACHE;
   logic [2:0]                      M_AXI_AWPROT;
   logic [3:0]                      M_AXI_AWQOS;
   logic [AWU_W-1:0]                M_AXI_AWUSER;
   logic                            M_AXI_AWVALID;
   logic                            M_AXI_AWREADY;

   logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
   logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
   logic                            M_AXI_WLAST;
   logic [WU_W-1:0]                 M_AXI_WUSER;
   logic                            M_AXI_WVALID;
   logic                            M_AXI_WREADY;

   logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID;
   logic [1:0]                      M_AXI_BRESP;
   logic [BU_W-1:0]                 M_AXI_BUSER;
   logic                            M_AXI_BVALID;
   logic                            M_AXI_BREADY;

   modport master (
      output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
             M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
             M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID,
      output M_AXI_BREADY
   );

   modport slave (
      input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
             M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
             M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID,
      input  M_AXI_BREADY
   );
endinterface

// File: rtl/dma_write.sv
// dma_write: streams a byte range into memory as AXI4 INCR write bursts,
// one burst outstanding, never crossing a 4 KB page, at most 256 beats.
//
// Ports
//   ACLK, ARESETN        clock / synchronous active-low reset
//   i_start              rising edge starts a transfer (only when idle)
//   i_base_addr          destination byte address (aligned down to a beat)
//   i_byte_len           byte count, 0 = nothing to do
//   o_busy/o_done/o_error  busy level / 1-cycle finish pulse / sticky BRESP error
//   i_data/i_valid/o_ready stream input, passed straight onto the W channel
//   m_axi                AXI4 write channels (dma_write_if.master)
//
// Build option: DMA_WRITE_PARTIAL_STRB_EN -- when defined, the final beat of a
// transfer only enables the byte lanes that carry valid data; otherwise every
// beat writes all lanes (length rounded up to whole beats).
module dma_write #(
   parameter int C_M_AXI_ID_WIDTH     = 1,
   parameter int C_M_AXI_ADDR_WIDTH   = 32,
   parameter int C_M_AXI_DATA_WIDTH   = 128,
   parameter int C_M_AXI_AWUSER_WIDTH = 0,
   parameter int C_M_AXI_WUSER_WIDTH  = 0,
   parameter int C_M_AXI_BUSER_WIDTH  = 0
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          i_start,
   input  logic [31:0]                   i_base_addr,
   input  logic [31:0]                   i_byte_len,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_error,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   dma_write_if.master                   m_axi
);
   localparam int unsigned BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int unsigned LOG2_BEAT  = $clog2(BEAT_BYTES);
   localparam int          AW         = C_M_AXI_ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

   state_t        state_q, state_d;
   logic          start_q, start_d;
   logic [AW-1:0] cur_addr_q, cur_addr_d;
   logic [31:0]   bytes_rem_q, bytes_rem_d;
   logic [8:0]    beat_cnt_q, beat_cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          awvalid_q, awvalid_d;
   logic          bready_q, bready_d;

   logic          start_edge;
   logic          in_w;
   logic          w_hs;
   logic [32:0]   ceil_beats;
   logic [12:0]   page_beats;
   logic [8:0]    beats;
   logic [C_M_AXI_DATA_WIDTH/8-1:0] strb;

   assign start_edge = i_start & ~start_q;
   assign in_w       = (state_q == S_W);
   assign w_hs       = in_w & i_valid & m_axi.M_AXI_WREADY;

   // Beats of the next burst: limited by remaining data, the 4 KB page and 256.
   always_comb begin
      ceil_beats = ({1'b0, bytes_rem_q} + 33'(BEAT_BYTES - 1)) >> LOG2_BEAT;
      page_beats = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> LOG2_BEAT;
      beats      = 9'd256;
      if (page_beats < 13'(beats)) beats = page_beats[8:0];
      if (ceil_beats < 33'(beats)) beats = ceil_beats[8:0];
   end

   always_comb begin
      strb = '1;
`ifdef DMA_WRITE_PARTIAL_STRB_EN
      // Final beat of the transfer with a partial remainder: enable low lanes only.
      if (bytes_rem_q <= 32'(BEAT_BYTES) &&
          (bytes_rem_q & 32'(BEAT_BYTES - 1)) != 32'd0) begin
         for (int unsigned i = 0; i < BEAT_BYTES; i++)
            strb[i] = (32'(i) < (bytes_rem_q & 32'(BEAT_BYTES - 1)));
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      start_d     = i_start;
      cur_addr_d  = cur_addr_q;
      bytes_rem_d = bytes_rem_q;
      beat_cnt_d  = beat_cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      awvalid_d   = awvalid_q;
      bready_d    = bready_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               error_d = 1'b0;
               if (i_byte_len != 32'd0) begin
                  cur_addr_d  = AW'(i_base_addr) & ~AW'(BEAT_BYTES - 1);
                  bytes_rem_d = i_byte_len;
                  busy_d      = 1'b1;
                  awvalid_d   = 1'b1;
                  state_d     = S_AW;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_AW: begin
            if (awvalid_q && m_axi.M_AXI_AWREADY) begin
               beat_cnt_d = beats;
               cur_addr_d = cur_addr_q + (AW'(beats) << LOG2_BEAT);
               awvalid_d  = 1'b0;
               state_d    = S_W;
            end
         end
         S_W: begin
            if (w_hs) begin
               beat_cnt_d  = beat_cnt_q - 9'd1;
               bytes_rem_d = bytes_rem_q - ((bytes_rem_q < 32'(BEAT_BYTES)) ?
                                            bytes_rem_q : 32'(BEAT_BYTES));
               if (beat_cnt_q == 9'd1) begin
                  bready_d = 1'b1;
                  state_d  = S_B;
               end
            end
         end
         S_B: begin
            if (m_axi.M_AXI_BVALID) begin
               if (m_axi.M_AXI_BRESP != 2'b00) error_d = 1'b1;
               bready_d = 1'b0;
               // An error response does not stop the remaining bursts.
               if (bytes_rem_q != 32'd0) begin
                  awvalid_d = 1'b1;
                  state_d   = S_AW;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b0;
         cur_addr_q  <= '0;
         bytes_rem_q <= '0;
         beat_cnt_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         awvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         cur_addr_q  <= cur_addr_d;
         bytes_rem_q <= bytes_rem_d;
         beat_cnt_q  <= beat_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         awvalid_q   <= awvalid_d;
         bready_q    <= bready_d;
      end
   end

   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_error = error_q;
   assign o_ready = in_w & m_axi.M_AXI_WREADY;

   assign m_axi.M_AXI_AWID    = '0;
   assign m_axi.M_AXI_AWADDR  = cur_addr_q;
   assign m_axi.M_AXI_AWLEN   = 8'(beats - 9'd1);
   assign m_axi.M_AXI_AWSIZE  = 3'(LOG2_BEAT);
   assign m_axi.M_AXI_AWBURST = 2'b01;
   assign m_axi.M_AXI_AWLOCK  = 1'b0;
   assign m_axi.M_AXI_AWCACHE = 4'b0011;
   assign m_axi.M_AXI_AWPROT  = '0;
   assign m_axi.M_AXI_AWQOS   = '0;
   assign m_axi.M_AXI_AWUSER  = '0;
   assign m_axi.M_AXI_AWVALID = awvalid_q;

   assign m_axi.M_AXI_WDATA   = i_data;
   assign m_axi.M_AXI_WSTRB   = strb;
   assign m_axi.M_AXI_WLAST   = in_w && (beat_cnt_q == 9'd1);
   assign m_axi.M_AXI_WUSER   = '0;
   assign m_axi.M_AXI_WVALID  = in_w & i_valid;

   assign m_axi.M_AXI_BREADY  = bready_q;

   logic unused_b_sigs;
   assign unused_b_sigs = ^{m_axi.M_AXI_BID, m_axi.M_AXI_BUSER};
endmodule

// File: tb/tb_dma_write.sv
module tb_dma_write;
   localparam int DW = 128;
   localparam int BB = DW / 8;
`ifdef DMA_WRITE_PARTIAL_STRB_EN
   localparam bit PARTIAL = 1'b1;
`else
   localparam bit PARTIAL = 1'b0;
`endif

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic          i_start;
   logic [31:0]   i_base_addr, i_byte_len;
   logic          o_busy, o_done, o_error;
   logic [DW-1:0] i_data;
   logic          i_valid, o_ready;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 ACLK = ~ACLK;

   dma_write_if #(
      .C_M_AXI_ID_WIDTH(1), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(DW),
      .C_M_AXI_AWUSER_WIDTH(0), .C_M_AXI_WUSER_WIDTH(0), .C_M_AXI_BUSER_WIDTH(0)
   ) axi ();

   dma_write #(
      .C_M_AXI_ID_WIDTH(1), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(DW),
      .C_M_AXI_AWUSER_WIDTH(0), .C_M_AXI_WUSER_WIDTH(0), .C_M_AXI_BUSER_WIDTH(0)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .i_start(i_start),
      .i_base_addr(i_base_addr), .i_byte_len(i_byte_len),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
      .m_axi(axi)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Reference model: expected bursts as (address, AWLEN) pairs.
   logic [31:0] q_addr[$];
   logic [7:0]  q_len[$];
   bit          exp_err = 1'b0;

   task automatic plan_bursts(input logic [31:0] base, input logic [31:0] len);
      longint unsigned addr, rem, cb, pb, b, take;
      q_addr.delete();
      q_len.delete();
      addr = longint'(base) & 64'hFFFF_FFF0;
      rem  = len;
      while (rem != 0) begin
         cb = (rem + BB - 1) / BB;
         pb = (4096 - (addr % 4096)) / BB;
         b  = 256;
         if (pb < b) b = pb;
         if (cb < b) b = cb;
         q_addr.push_back(32'(addr));
         q_len.push_back(8'(b - 1));
         take = (b * BB > rem) ? rem : b * BB;
         rem  = rem - take;
         addr = (addr + b * BB) % 64'h1_0000_0000;
      end
   endtask

   // stall: random back-pressure; err_burst: burst index answered with SLVERR
   // (-1 none); rst_at: cycle at which reset is pulsed (-1 none).
   task automatic run_xfer(input logic [31:0] base, input logic [31:0] len,
                           input bit stall, input int err_burst, input int rst_at);
      int          ph;         // 0 idle, 1 address, 2 data, 3 response
      bit          done_exp;
      bit          finished;
      int          cyc;
      int          bidx;
      int          beat;
      logic [7:0]  cur_len;
      longint      w_rem;
      logic [15:0] es;
      logic        awready, wready, bvalid;

      plan_bursts(base, len);
      @(negedge ACLK);
      i_start = 1'b0;
      @(negedge ACLK);
      i_start     = 1'b1;
      i_base_addr = base;
      i_byte_len  = len;
      exp_err  = 1'b0;
      ph       = (len != 0) ? 1 : 0;
      done_exp = (len == 0);
      finished = 1'b0;
      cyc = 0; bidx = 0; beat = 0; cur_len = '0;
      w_rem = len;

      while (!finished && cyc < 20000) begin
         @(negedge ACLK);
         cyc++;
         check_eq("busy",    o_busy,                  ph != 0);
         check_eq("done",    o_done,                  done_exp);
         check_eq("error",   o_error,                 exp_err);
         check_eq("awvalid", axi.M_AXI_AWVALID,       ph == 1);
         check_eq("bready",  axi.M_AXI_BREADY,        ph == 3);
         if (done_exp) begin
            finished = 1'b1;
            break;
         end
         if (cyc == rst_at) begin
            ARESETN = 1'b0;
            i_start = 1'b0;
            @(posedge ACLK);
            @(negedge ACLK);
            check_eq("reset_outs", {o_busy, o_done, o_error, axi.M_AXI_AWVALID,
                                    axi.M_AXI_WVALID, axi.M_AXI_BREADY, o_ready}, '0);
            ARESETN = 1'b1;
            exp_err = 1'b0;
            return;
         end

         awready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         bvalid  = (ph == 3) && (stall ? ($urandom_range(0, 1) != 0) : 1'b1);
         axi.M_AXI_AWREADY = awready;
         axi.M_AXI_WREADY  = wready;
         axi.M_AXI_BVALID  = bvalid;
         axi.M_AXI_BRESP   = (bvalid && bidx == err_burst) ? 2'b10 : 2'b00;
         axi.M_AXI_BID     = 1'($urandom);
         axi.M_AXI_BUSER   = 1'($urandom);
         i_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         i_data  = {$urandom, $urandom, $urandom, $urandom};
         i_start = (ph == 1 || ph == 2) ? 1'($urandom) : 1'b0;
         #1;

         check_eq("wvalid", axi.M_AXI_WVALID, (ph == 2) && i_valid);
         check_eq("oready", o_ready,          (ph == 2) && wready);

         if (ph == 1) begin
            check_eq("awaddr", axi.M_AXI_AWADDR, q_addr[0]);
            check_eq("awlen",  axi.M_AXI_AWLEN,  q_len[0]);
            if (awready) begin
               check_eq("aw_const", {axi.M_AXI_AWID, axi.M_AXI_AWSIZE, axi.M_AXI_AWBURST,
                                     axi.M_AXI_AWLOCK, axi.M_AXI_AWCACHE, axi.M_AXI_AWPROT,
                                     axi.M_AXI_AWQOS, axi.M_AXI_AWUSER},
                        {1'b0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0});
               cur_len = q_len.pop_front();
               void'(q_addr.pop_front());
               beat = 0;
               ph   = 2;
            end
         end else if (ph == 2) begin
            if (i_valid && wready) begin
               if (PARTIAL && w_rem <= BB && (w_rem % BB) != 0)
                  es = 16'((32'd1 << (w_rem % BB)) - 1);
               else
                  es = 16'hFFFF;
               check_eq("wdata", axi.M_AXI_WDATA, i_data);
               check_eq("wstrb", axi.M_AXI_WSTRB, es);
               check_eq("wlast", axi.M_AXI_WLAST, beat == int'(cur_len));
               w_rem = w_rem - ((w_rem < BB) ? w_rem : BB);
               if (beat == int'(cur_len)) ph = 3;
               beat++;
            end
         end else if (ph == 3) begin
            if (bvalid) begin
               if (axi.M_AXI_BRESP != 2'b00) exp_err = 1'b1;
               bidx++;
               if (q_addr.size() == 0) begin
                  ph       = 0;
                  done_exp = 1'b1;
               end else begin
                  ph = 1;
               end
            end
         end
      end
      if (!finished) check_eq("timeout", 1'b0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ARESETN     = 1'b0;
      i_start     = 1'b0;
      i_base_addr = '0;
      i_byte_len  = '0;
      i_data      = '0;
      i_valid     = 1'b0;
      axi.M_AXI_AWREADY = 1'b0;
      axi.M_AXI_WREADY  = 1'b0;
      axi.M_AXI_BVALID  = 1'b0;
      axi.M_AXI_BRESP   = 2'b00;
      axi.M_AXI_BID     = '0;
      axi.M_AXI_BUSER   = '0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check_eq("reset_state", {o_busy, o_done, o_error, axi.M_AXI_AWVALID,
                               axi.M_AXI_WVALID, axi.M_AXI_BREADY, o_ready}, '0);
      ARESETN = 1'b1;

      run_xfer(32'h0000_1000, 32'd64,   1'b0, -1, -1);
      run_xfer(32'h0000_1FC0, 32'd128,  1'b0, -1, -1);
      run_xfer(32'h0000_0000, 32'd4128, 1'b1, -1, -1);
      run_xfer(32'h0000_0300, 32'd20,   1'b1, -1, -1);
      run_xfer(32'h0000_1FC0, 32'd128,  1'b1,  1, -1);
      run_xfer(32'h0000_0000, 32'd0,    1'b1, -1, -1);
      run_xfer(32'h0000_5008, 32'd200,  1'b1, -1, -1);
      run_xfer(32'h0000_2000, 32'd1024, 1'b1, -1,  6);
      run_xfer(32'h0000_2000, 32'd1024, 1'b1, -1, -1);
      for (int i = 0; i < 8; i++)
         run_xfer($urandom, 32'($urandom_range(1, 2000)), 1'b1,
                  $urandom_range(0, 3) - 1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
